// File: rtl/yaklasik_pkg.sv
// Shared types and constants for the approximate memoizing divider.
// Cache entry layout, LSB first: kalan | bolum | etiket_b | etiket_a.
package yaklasik_pkg;

   localparam int N_VARSAYILAN        = 32;
   localparam int ETIKET_VARSAYILAN   = 4;
   localparam int DERINLIK_VARSAYILAN = 8;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ARA   = 2'd1,
      BOL   = 2'd2,
      YAZ   = 2'd3
   } durum_t;

   localparam int KALAN_LSB = 0;

   function automatic int bolum_lsb(input int n);
      return n;
   endfunction

   function automatic int etiket_b_lsb(input int n);
      return 2 * n;
   endfunction

   function automatic int etiket_a_lsb(input int n, input int e);
      return 2 * n + e;
   endfunction

   function automatic int giris_genislik(input int n, input int e);
      return 2 * n + 2 * e;
   endfunction

endpackage

// File: rtl/yaklasik_bellek.sv
// Result cache: tag/data array, valid bits, round-robin write pointer.
// Lookup is combinational; the lowest matching index wins.
module yaklasik_bellek
   import yaklasik_pkg::*;
#(
   parameter int N        = N_VARSAYILAN,
   parameter int ETIKET   = ETIKET_VARSAYILAN,
   parameter int DERINLIK = DERINLIK_VARSAYILAN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ETIKET-1:0] ara_a,
   input  logic [ETIKET-1:0] ara_b,
   output logic              isabet,
   output logic [N-1:0]      oku_bolum,
   output logic [N-1:0]      oku_kalan,
   input  logic              yaz,
   input  logic [ETIKET-1:0] yaz_a,
   input  logic [ETIKET-1:0] yaz_b,
   input  logic [N-1:0]      yaz_bolum,
   input  logic [N-1:0]      yaz_kalan
);

   localparam int IW  = $clog2(DERINLIK);
   localparam int GEN = giris_genislik(N, ETIKET);
   localparam int BL  = bolum_lsb(N);
   localparam int EB  = etiket_b_lsb(N);
   localparam int EA  = etiket_a_lsb(N, ETIKET);

   logic [GEN-1:0]      giris [DERINLIK];
   logic [DERINLIK-1:0] gecerli_bit;
   logic [IW-1:0]       isaretci;
   logic [IW-1:0]       bulunan;

   // Scanning downward lets the lowest matching index overwrite the others.
   always_comb begin
      isabet  = 1'b0;
      bulunan = '0;
      for (int i = DERINLIK - 1; i >= 0; i--) begin
         if (gecerli_bit[i] && giris[i][EA +: ETIKET] == ara_a &&
             giris[i][EB +: ETIKET] == ara_b) begin
            isabet  = 1'b1;
            bulunan = IW'(i);
         end
      end
   end

   assign oku_bolum = giris[bulunan][BL +: N];
   assign oku_kalan = giris[bulunan][KALAN_LSB +: N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gecerli_bit <= '0;
         isaretci    <= '0;
      end else if (yaz) begin
         gecerli_bit[isaretci] <= 1'b1;
         isaretci              <= isaretci + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (yaz) giris[isaretci] <= {yaz_a, yaz_b, yaz_bolum, yaz_kalan};
   end

endmodule

// File: rtl/yaklasik_bolme.sv
// Approximate memoizing divider: restoring N-bit divider behind a tag cache.
//   state | meaning
//   BOSTA | idle, waiting for basla
//   ARA   | zero-divisor / cache check; hit results staged one cycle
//   BOL   | one restoring iteration per cycle, MSB first
//   YAZ   | record result in cache, present outputs
module yaklasik_bolme
   import yaklasik_pkg::*;
#(
   parameter int N        = N_VARSAYILAN,
   parameter int ETIKET   = ETIKET_VARSAYILAN,
   parameter int DERINLIK = DERINLIK_VARSAYILAN
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         basla,
   input  logic [N-1:0] bolunen,
   input  logic [N-1:0] bolen,
   output logic [N-1:0] bolum,
   output logic [N-1:0] kalan,
   output logic         gecerli,
   output logic         mesgul,
   output logic         isabet,
   output logic         sifira_bolme
);

   localparam int SW = $clog2(N);

   durum_t         durum;
   logic [N-1:0]   bolunen_r;
   logic [N-1:0]   bolen_r;
   logic [N-1:0]   q_r;
   logic [N-1:0]   r_r;
   logic [SW-1:0]  sayac;
   logic           ara_bekle;
   logic           st_isabet;
   logic           st_sifir;
   logic [N:0]     kaydir;
   logic [N:0]     fark;
   logic           bellek_isabet;
   logic [N-1:0]   bellek_bolum;
   logic [N-1:0]   bellek_kalan;

   // A borrow out of the N+1-bit subtraction means the divisor did not fit.
   assign kaydir = {r_r, q_r[N-1]};
   assign fark   = kaydir - {1'b0, bolen_r};

   yaklasik_bellek #(
      .N        (N),
      .ETIKET   (ETIKET),
      .DERINLIK (DERINLIK)
   ) u_bellek (
      .clk       (clk),
      .rst_n     (rst_n),
      .ara_a     (bolunen_r[N-1 -: ETIKET]),
      .ara_b     (bolen_r[N-1 -: ETIKET]),
      .isabet    (bellek_isabet),
      .oku_bolum (bellek_bolum),
      .oku_kalan (bellek_kalan),
      .yaz       (durum == YAZ),
      .yaz_a     (bolunen_r[N-1 -: ETIKET]),
      .yaz_b     (bolen_r[N-1 -: ETIKET]),
      .yaz_bolum (q_r),
      .yaz_kalan (r_r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         durum        <= BOSTA;
         bolunen_r    <= '0;
         bolen_r      <= '0;
         q_r          <= '0;
         r_r          <= '0;
         sayac        <= '0;
         ara_bekle    <= 1'b0;
         st_isabet    <= 1'b0;
         st_sifir     <= 1'b0;
         bolum        <= '0;
         kalan        <= '0;
         gecerli      <= 1'b0;
         mesgul       <= 1'b0;
         isabet       <= 1'b0;
         sifira_bolme <= 1'b0;
      end else begin
         gecerli <= 1'b0;
         case (durum)
            BOSTA: begin
               if (basla) begin
                  bolunen_r <= bolunen;
                  bolen_r   <= bolen;
                  mesgul    <= 1'b1;
                  durum     <= ARA;
               end
            end
            ARA: begin
               if (ara_bekle) begin
                  bolum        <= q_r;
                  kalan        <= r_r;
                  isabet       <= st_isabet;
                  sifira_bolme <= st_sifir;
                  gecerli      <= 1'b1;
                  mesgul       <= 1'b0;
                  ara_bekle    <= 1'b0;
                  durum        <= BOSTA;
               end else if (bolen_r == '0) begin
                  q_r       <= '1;
                  r_r       <= bolunen_r;
                  st_isabet <= 1'b0;
                  st_sifir  <= 1'b1;
                  ara_bekle <= 1'b1;
               end else if (bellek_isabet) begin
                  q_r       <= bellek_bolum;
                  r_r       <= bellek_kalan;
                  st_isabet <= 1'b1;
                  st_sifir  <= 1'b0;
                  ara_bekle <= 1'b1;
               end else begin
                  q_r   <= bolunen_r;
                  r_r   <= '0;
                  sayac <= SW'(N - 1);
                  durum <= BOL;
               end
            end
            BOL: begin
               q_r <= {q_r[N-2:0], ~fark[N]};
               r_r <= fark[N] ? kaydir[N-1:0] : fark[N-1:0];
               if (sayac == '0) durum <= YAZ;
               else             sayac <= sayac - 1'b1;
            end
            YAZ: begin
               bolum        <= q_r;
               kalan        <= r_r;
               isabet       <= 1'b0;
               sifira_bolme <= 1'b0;
               gecerli      <= 1'b1;
               mesgul       <= 1'b0;
               durum        <= BOSTA;
            end
            default: durum <= BOSTA;
         endcase
      end
   end

endmodule

// File: tb/tb_yaklasik_bolme.sv
// Scoreboard bench for yaklasik_bolme: driver pushes model results, monitor pops on gecerli.
module tb_yaklasik_bolme;

   localparam int N = 32;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          basla = 1'b0;
   logic [N-1:0]  bolunen = '0;
   logic [N-1:0]  bolen = '0;
   logic [N-1:0]  bolum;
   logic [N-1:0]  kalan;
   logic          gecerli;
   logic          mesgul;
   logic          isabet;
   logic          sifira_bolme;

   always #5 clk = ~clk;

   yaklasik_bolme dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .basla        (basla),
      .bolunen      (bolunen),
      .bolen        (bolen),
      .bolum        (bolum),
      .kalan        (kalan),
      .gecerli      (gecerli),
      .mesgul       (mesgul),
      .isabet       (isabet),
      .sifira_bolme (sifira_bolme)
   );

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         h;
      logic         z;
      longint       cyc;
   } beklenen_t;

   beklenen_t   exp_q[$];
   int          tests = 0;
   int          fails = 0;
   longint      cyc = 0;

   // reference cache: tags, results, valid flags, round-robin slot
   logic        m_v  [D];
   logic [3:0]  m_ta [D];
   logic [3:0]  m_tb [D];
   logic [N-1:0] m_q [D];
   logic [N-1:0] m_r [D];
   int          m_ptr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      m_ptr = 0;
   endtask

   task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                        output beklenen_t e, output int lat);
      int bul;
      bul = -1;
      e.cyc = 0;
      if (b == 0) begin
         e.q = '1; e.r = a; e.h = 1'b0; e.z = 1'b1; lat = 2;
         return;
      end
      for (int i = 0; i < D; i++) begin
         if (bul < 0 && m_v[i] && m_ta[i] == a[N-1 -: 4] && m_tb[i] == b[N-1 -: 4]) bul = i;
      end
      e.z = 1'b0;
      if (bul >= 0) begin
         e.q = m_q[bul]; e.r = m_r[bul]; e.h = 1'b1; lat = 2;
      end else begin
         e.q = a / b; e.r = a % b; e.h = 1'b0; lat = N + 2;
         m_v[m_ptr] = 1'b1; m_ta[m_ptr] = a[N-1 -: 4]; m_tb[m_ptr] = b[N-1 -: 4];
         m_q[m_ptr] = e.q; m_r[m_ptr] = e.r;
         m_ptr = (m_ptr + 1) % D;
      end
   endtask

   always @(negedge clk) begin
      beklenen_t e;
      if (rst_n && gecerli) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_gecerli: actual bolum=%0h kalan=%0h, required no output", bolum, kalan);
         end else begin
            e = exp_q.pop_front();
            chk("bolum", 64'(bolum), 64'(e.q));
            chk("kalan", 64'(kalan), 64'(e.r));
            chk("isabet", 64'(isabet), 64'(e.h));
            chk("sifira_bolme", 64'(sifira_bolme), 64'(e.z));
            chk("latency", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      beklenen_t e;
      int lat;
      int n = 0;
      while (mesgul && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("issue_timeout", 64'(mesgul), 64'd0);
      model(a, b, e, lat);
      e.cyc = cyc + 1 + lat;
      exp_q.push_back(e);
      basla = 1'b1; bolunen = a; bolen = b;
      @(negedge clk);
      basla = 1'b0;
      chk("mesgul_after_accept", 64'(mesgul), 64'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || mesgul) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      chk("rst_gecerli", 64'(gecerli), 64'd0);
      chk("rst_mesgul", 64'(mesgul), 64'd0);
      chk("rst_bolum", 64'(bolum), 64'd0);
      chk("rst_kalan", 64'(kalan), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [N-1:0] pa [9];
   logic [N-1:0] pb [9];

   initial begin
      logic [3:0] ta, tb;
      logic [N-1:0] ra, rb;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_bolum", 64'(bolum), 64'd0);
      chk("reset_kalan", 64'(kalan), 64'd0);
      chk("reset_gecerli", 64'(gecerli), 64'd0);
      chk("reset_mesgul", 64'(mesgul), 64'd0);
      chk("reset_isabet", 64'(isabet), 64'd0);
      chk("reset_sifira_bolme", 64'(sifira_bolme), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'd100, 32'd7);
      wait_idle();
      issue(32'd105, 32'd9);
      wait_idle();

      do_reset();
      issue(32'h0000_1234, 32'd0);
      issue(32'h0000_1234, 32'd5);
      wait_idle();

      do_reset();
      for (int i = 0; i < 9; i++) begin
         pa[i] = {4'(i + 1), 28'($urandom)};
         pb[i] = {4'h1, 28'($urandom)};
         issue(pa[i], pb[i]);
      end
      wait_idle();
      issue(pa[1] ^ 32'h0000_0F0F, pb[1]);
      issue(pa[0], pb[0]);
      wait_idle();

      issue(32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      basla = 1'b1; bolunen = 32'd7; bolen = 32'd0;
      @(negedge clk);
      basla = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);

      issue(32'hA000_0064, 32'hB000_0007);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      chk("midbol_rst_bolum", 64'(bolum), 64'd0);
      chk("midbol_rst_kalan", 64'(kalan), 64'd0);
      chk("midbol_rst_mesgul", 64'(mesgul), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(32'd100, 32'd7);
      wait_idle();

      repeat (40) begin
         ta = 4'($urandom_range(0, 3));
         tb = 4'($urandom_range(0, 2));
         ra = {ta, 28'($urandom)};
         rb = ($urandom_range(0, 7) == 0) ? '0 : {tb, 28'($urandom)};
         issue(ra, rb);
      end
      wait_idle();
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
